// File: rtl/bla_poly_rasterizer.sv
// Bresenham rasteriser for an open line or a closed polygon outline.
// Streams each drawn pixel over valid/ready and records it in a WxH bitmap.
module bla_poly_rasterizer #(
    parameter int unsigned COORD_W   = 8,
    parameter int unsigned BUF_W     = 64,
    parameter int unsigned BUF_H     = 64,
    parameter int unsigned MAX_VERTS = 4,
    parameter int unsigned VCNT_W    = $clog2(MAX_VERTS + 1)
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic                           start,
    input  logic [VCNT_W-1:0]              vert_count,
    input  logic [2*COORD_W*MAX_VERTS-1:0] coordinates,
    input  logic                           pix_ready,
    output logic                           pix_valid,
    output logic [COORD_W-1:0]             pix_x,
    output logic [COORD_W-1:0]             pix_y,
    output logic                           busy,
    output logic                           bla_done,
    output logic                           err,
    output logic [BUF_W*BUF_H-1:0]         line_buffer
);

    localparam int unsigned SW    = COORD_W + 2;
    localparam int unsigned NPTS  = 2 ** VCNT_W;
    localparam int unsigned PAD_W = 2 * COORD_W * NPTS;
    localparam int unsigned IDX_W = $clog2(BUF_W * BUF_H);

    typedef enum logic [2:0] {StIdle, StLoad, StSetup, StStep, StNext, StDone} state_e;

    state_e state_q, state_d;

    logic [VCNT_W-1:0]              vcnt_q;
    logic [2*COORD_W*MAX_VERTS-1:0] coords_q;
    logic [VCNT_W-1:0]              e_q;
    logic [COORD_W-1:0]             cx_q, cy_q, x1_q, y1_q;
    logic signed [SW-1:0]           dx_q, dy_q, acc_q;
    logic                           sx_q, sy_q;
    logic                           illegal_q;
    logic [BUF_W*BUF_H-1:0]         lbuf_q;

    // Vertex table padded to a power of two so the edge index needs no range guard.
    logic [PAD_W-1:0]   crd_pad;
    logic [COORD_W-1:0] px [NPTS];
    logic [COORD_W-1:0] py [NPTS];

    // Unpack latched coordinates into per-vertex x/y tables.
    always_comb begin
        crd_pad = PAD_W'(coords_q);
        for (int i = 0; i < NPTS; i++) begin
            px[i] = crd_pad[2*COORD_W*i +: COORD_W];
            py[i] = crd_pad[2*COORD_W*i+COORD_W +: COORD_W];
        end
    end

    logic [VCNT_W-1:0] e_end;
    logic              closed, last_edge, legal_in;
    logic              at_end, in_range, emit, handled;
    logic [IDX_W-1:0]  pix_idx;

    // Edge bookkeeping and per-pixel emit decision.
    always_comb begin
        closed    = (vcnt_q != VCNT_W'(2));
        e_end     = (e_q == vcnt_q - VCNT_W'(1)) ? '0 : e_q + VCNT_W'(1);
        last_edge = closed ? (e_q == vcnt_q - VCNT_W'(1)) : (e_q == '0);
        legal_in  = (vert_count >= VCNT_W'(2)) && (vert_count <= VCNT_W'(MAX_VERTS));
        at_end    = (cx_q == x1_q) && (cy_q == y1_q);
        in_range  = (32'(cx_q) < BUF_W) && (32'(cy_q) < BUF_H);
        // Closed shapes drop each edge's end pixel; the next edge starts on it.
        emit      = !(closed && at_end) && in_range;
        handled   = !emit || pix_ready;
        pix_idx   = IDX_W'(32'(cy_q) * BUF_W + 32'(cx_q));
    end

    logic signed [SW-1:0] ax0, ay0, ax1, ay1, ddx, ddy;
    logic signed [SW-1:0] setup_dx, setup_dy;
    logic                 setup_sx, setup_sy;

    // Edge setup: deltas, step directions and initial error term.
    always_comb begin
        ax0      = $signed({2'b00, px[e_q]});
        ay0      = $signed({2'b00, py[e_q]});
        ax1      = $signed({2'b00, px[e_end]});
        ay1      = $signed({2'b00, py[e_end]});
        ddx      = ax1 - ax0;
        ddy      = ay1 - ay0;
        setup_sx = ~ddx[SW-1];
        setup_sy = ~ddy[SW-1];
        setup_dx = ddx[SW-1] ? -ddx : ddx;
        setup_dy = ddy[SW-1] ? ddy : -ddy;
    end

    logic signed [SW-1:0] e2, acc_step;
    logic [COORD_W-1:0]   cx_step, cy_step;

    // One Bresenham step from the current pixel.
    always_comb begin
        e2       = acc_q <<< 1;
        acc_step = acc_q;
        cx_step  = cx_q;
        cy_step  = cy_q;
        if (e2 >= dy_q) begin
            acc_step = acc_step + dy_q;
            cx_step  = sx_q ? cx_q + COORD_W'(1) : cx_q - COORD_W'(1);
        end
        if (e2 <= dx_q) begin
            acc_step = acc_step + dx_q;
            cy_step  = sy_q ? cy_q + COORD_W'(1) : cy_q - COORD_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state decode and control outputs.
    always_comb begin
        state_d   = state_q;
        pix_valid = 1'b0;
        busy      = 1'b0;
        bla_done  = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad: begin
                busy    = 1'b1;
                state_d = legal_in ? StSetup : StDone;
            end
            StSetup: begin
                busy    = 1'b1;
                state_d = StStep;
            end
            StStep: begin
                busy      = 1'b1;
                pix_valid = emit;
                // Last edge goes straight to DONE; inner edges pay NEXT+SETUP.
                if (handled && at_end) state_d = last_edge ? StDone : StNext;
            end
            StNext: begin
                busy    = 1'b1;
                state_d = StSetup;
            end
            StDone: begin
                bla_done = 1'b1;
                err      = illegal_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: primitive latch, edge setup, stepping and bitmap update.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vcnt_q    <= '0;
            coords_q  <= '0;
            e_q       <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            acc_q     <= '0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            illegal_q <= 1'b0;
            lbuf_q    <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    vcnt_q    <= vert_count;
                    coords_q  <= coordinates;
                    e_q       <= '0;
                    illegal_q <= !legal_in;
                    lbuf_q    <= '0;
                end
                StSetup: begin
                    cx_q  <= px[e_q];
                    cy_q  <= py[e_q];
                    x1_q  <= px[e_end];
                    y1_q  <= py[e_end];
                    dx_q  <= setup_dx;
                    dy_q  <= setup_dy;
                    sx_q  <= setup_sx;
                    sy_q  <= setup_sy;
                    acc_q <= setup_dx + setup_dy;
                end
                StStep: begin
                    if (emit) lbuf_q[pix_idx] <= 1'b1;
                    if (handled && !at_end) begin
                        cx_q  <= cx_step;
                        cy_q  <= cy_step;
                        acc_q <= acc_step;
                    end
                end
                StNext:  e_q <= e_q + VCNT_W'(1);
                default: ;
            endcase
        end
    end

    assign pix_x       = cx_q;
    assign pix_y       = cy_q;
    assign line_buffer = lbuf_q;

endmodule

// File: tb/tb_bla_poly_rasterizer.sv
// Self-checking bench for bla_poly_rasterizer against a plain-integer reference model.
module tb_bla_poly_rasterizer;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [2:0]    vert_count;
    logic [63:0]   coordinates;
    logic          pix_ready;
    logic          pix_valid;
    logic [7:0]    pix_x, pix_y;
    logic          busy, bla_done, err;
    logic [4095:0] line_buffer;

    bla_poly_rasterizer dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .vert_count  (vert_count),
        .coordinates (coordinates),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .busy        (busy),
        .bla_done    (bla_done),
        .err         (err),
        .line_buffer (line_buffer)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int got_x[$], got_y[$], exp_x[$], exp_y[$];
    logic [4095:0] exp_buf;
    int exp_done;
    int done_cycle, done_count, err_at_done, err_stray, stab_viol, first_valid;
    logic busy_at1, busy_at_done;

    function automatic logic [63:0] pack4(input int x0, input int y0, input int x1, input int y1,
                                          input int x2, input int y2, input int x3, input int y3);
        return {8'(y3), 8'(x3), 8'(y2), 8'(x2), 8'(y1), 8'(x1), 8'(y0), 8'(x0)};
    endfunction

    // Reference: walk every edge with integer Bresenham and apply the emit/clip rules.
    task automatic model(input int n, input logic [63:0] crd);
        int xs[4], ys[4];
        int edges, visited, x, y, x1, y1, dx, dy, sx, sy, er, e2;
        bit fin;
        exp_x.delete();
        exp_y.delete();
        exp_buf = '0;
        if (n < 2 || n > 4) begin
            exp_done = 2;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            xs[i] = int'(crd[16*i +: 8]);
            ys[i] = int'(crd[16*i+8 +: 8]);
        end
        edges   = (n == 2) ? 1 : n;
        visited = 0;
        for (int e = 0; e < edges; e++) begin
            x  = xs[e];
            y  = ys[e];
            x1 = xs[(e + 1) % n];
            y1 = ys[(e + 1) % n];
            dx = (x1 > x) ? x1 - x : x - x1;
            dy = (y1 > y) ? y - y1 : y1 - y;
            sx = (x1 >= x) ? 1 : -1;
            sy = (y1 >= y) ? 1 : -1;
            er = dx + dy;
            fin = 0;
            while (!fin) begin
                visited++;
                fin = (x == x1 && y == y1);
                if (!(n > 2 && fin) && x < 64 && y < 64) begin
                    exp_x.push_back(x);
                    exp_y.push_back(y);
                    exp_buf[y*64+x] = 1'b1;
                end
                if (!fin) begin
                    e2 = 2 * er;
                    if (e2 >= dy) begin er += dy; x += sx; end
                    if (e2 <= dx) begin er += dx; y += sy; end
                end
            end
        end
        exp_done = 3 + visited + 2 * (edges - 1);
    endtask

    // Drives one primitive and records what the DUT produced. mode: 0 ready=1, 1 toggle, 2 random.
    task automatic run_prim(input int n, input logic [63:0] crd, input int mode,
                            input int restart_at, input int budget);
        bit prev_stall = 0;
        logic [7:0] px = 0, py = 0;
        got_x.delete();
        got_y.delete();
        done_cycle = -1; done_count = 0; err_at_done = 0; err_stray = 0;
        stab_viol = 0; first_valid = -1; busy_at1 = 0; busy_at_done = 1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            vert_count  = 3'(n);
            coordinates = crd;
            start       = (c == 0 || c == restart_at);
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (c % 2 == 0);
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
            if (c == 1) busy_at1 = busy;
            if (prev_stall && !(pix_valid && pix_x == px && pix_y == py)) stab_viol++;
            prev_stall = pix_valid && !pix_ready;
            px = pix_x;
            py = pix_y;
            if (pix_valid) begin
                if (first_valid < 0) first_valid = c;
                if (pix_ready) begin
                    got_x.push_back(int'(pix_x));
                    got_y.push_back(int'(pix_y));
                end
            end
            if (bla_done) begin
                done_count++;
                if (done_cycle < 0) begin
                    done_cycle   = c;
                    busy_at_done = busy;
                    err_at_done  = err;
                end
            end else if (err) err_stray++;
            if (done_cycle >= 0 && c >= done_cycle + 2) break;
        end
        @(negedge clk);
        start     = 1'b0;
        pix_ready = 1'b1;
    endtask

    function automatic int seq_diff();
        int d;
        d = (got_x.size() > exp_x.size()) ? got_x.size() - exp_x.size()
                                          : exp_x.size() - got_x.size();
        for (int i = 0; i < got_x.size() && i < exp_x.size(); i++)
            if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; pix_ready = 1'b1; vert_count = '0; coordinates = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pix_valid, busy, bla_done, err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b want=0000", {pix_valid, busy, bla_done, err});
        end
        checks++;
        if ({pix_x, pix_y} !== 16'h0 || line_buffer !== '0) begin
            errors++;
            $display("FAIL reset_data pix=%h bits=%0d want 0/0", {pix_x, pix_y},
                     $countones(line_buffer));
        end
        n_rst = 1'b1;
    endtask

    task automatic test_diag();
        logic [63:0] crd = pack4(0, 0, 23, 23, 0, 0, 0, 0);
        model(2, crd);
        run_prim(2, crd, 0, -1, 200);
        checks++;
        if (got_x.size() !== 24) begin
            errors++; $display("FAIL diag_count got=%0d want=24", got_x.size());
        end
        checks++;
        if (seq_diff() !== 0) begin
            errors++; $display("FAIL diag_seq diffs=%0d want=0", seq_diff());
        end
        checks++;
        if (first_valid !== 3) begin
            errors++; $display("FAIL diag_first_valid got=%0d want=3", first_valid);
        end
        checks++;
        if (done_cycle !== 27 || done_count !== 1 || err_at_done !== 0) begin
            errors++;
            $display("FAIL diag_done cyc=%0d cnt=%0d err=%0d want 27/1/0", done_cycle,
                     done_count, err_at_done);
        end
        checks++;
        if (busy_at1 !== 1'b1 || busy_at_done !== 1'b0) begin
            errors++;
            $display("FAIL diag_busy at1=%b atdone=%b want 1/0", busy_at1, busy_at_done);
        end
        checks++;
        if (line_buffer !== exp_buf) begin
            errors++;
            $display("FAIL diag_buf got_bits=%0d want_bits=%0d", $countones(line_buffer),
                     $countones(exp_buf));
        end
    endtask

    task automatic test_triangle();
        logic [63:0] crd = pack4(0, 0, 23, 23, 0, 23, 0, 0);
        model(3, crd);
        run_prim(3, crd, 0, -1, 400);
        checks++;
        if (got_x.size() !== 69 || seq_diff() !== 0) begin
            errors++;
            $display("FAIL tri_seq count=%0d diffs=%0d want 69/0", got_x.size(), seq_diff());
        end
        checks++;
        if ($countones(line_buffer) !== 69) begin
            errors++; $display("FAIL tri_popcount got=%0d want=69", $countones(line_buffer));
        end
        checks++;
        if ({line_buffer[0], line_buffer[23*64+23], line_buffer[23*64]} !== 3'b111) begin
            errors++;
            $display("FAIL tri_vertices got=%b want=111",
                     {line_buffer[0], line_buffer[23*64+23], line_buffer[23*64]});
        end
        checks++;
        if (done_cycle !== exp_done || done_count !== 1) begin
            errors++;
            $display("FAIL tri_done cyc=%0d cnt=%0d want %0d/1", done_cycle, done_count,
                     exp_done);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] crd = pack4(0, 0, 23, 23, 0, 0, 0, 0);
        model(2, crd);
        run_prim(2, crd, 1, -1, 400);
        checks++;
        if (seq_diff() !== 0 || got_x.size() !== 24) begin
            errors++;
            $display("FAIL bp_seq count=%0d diffs=%0d want 24/0", got_x.size(), seq_diff());
        end
        checks++;
        if (stab_viol !== 0) begin
            errors++; $display("FAIL bp_stable violations=%0d want=0", stab_viol);
        end
        checks++;
        if (done_count !== 1 || line_buffer !== exp_buf) begin
            errors++;
            $display("FAIL bp_done cnt=%0d bits=%0d want 1/%0d", done_count,
                     $countones(line_buffer), $countones(exp_buf));
        end
    endtask

    task automatic test_clip();
        logic [63:0] crd = pack4(60, 0, 70, 0, 0, 0, 0, 0);
        model(2, crd);
        run_prim(2, crd, 0, -1, 200);
        checks++;
        if (got_x.size() !== 4 || seq_diff() !== 0) begin
            errors++;
            $display("FAIL clip_seq count=%0d diffs=%0d want 4/0", got_x.size(), seq_diff());
        end
        checks++;
        if (line_buffer[64 +: 16] !== 16'h0 || line_buffer !== exp_buf) begin
            errors++;
            $display("FAIL clip_buf row1=%h bits=%0d want 0/%0d", line_buffer[64 +: 16],
                     $countones(line_buffer), $countones(exp_buf));
        end
        checks++;
        if (done_cycle !== exp_done || done_count !== 1) begin
            errors++;
            $display("FAIL clip_done cyc=%0d cnt=%0d want %0d/1", done_cycle, done_count,
                     exp_done);
        end
    endtask

    task automatic test_illegal();
        int ns[3] = '{1, 5, 0};
        for (int k = 0; k < 3; k++) begin
            run_prim(ns[k], pack4(1, 2, 3, 4, 5, 6, 7, 8), 0, -1, 50);
            checks++;
            if (got_x.size() !== 0 || first_valid !== -1) begin
                errors++;
                $display("FAIL illegal_nopix n=%0d pixels=%0d want 0", ns[k], got_x.size());
            end
            checks++;
            if (done_cycle !== 2 || done_count !== 1 || err_at_done !== 1 || err_stray !== 0)
            begin
                errors++;
                $display("FAIL illegal_done n=%0d cyc=%0d cnt=%0d err=%0d stray=%0d want 2/1/1/0",
                         ns[k], done_cycle, done_count, err_at_done, err_stray);
            end
        end
        checks++;
        if (line_buffer !== '0) begin
            errors++; $display("FAIL illegal_buf bits=%0d want=0", $countones(line_buffer));
        end
    endtask

    task automatic test_reset_midop();
        logic [63:0] tri_crd = pack4(0, 0, 23, 23, 0, 23, 0, 0);
        logic [63:0] diag    = pack4(0, 0, 23, 23, 0, 0, 0, 0);
        @(negedge clk);
        vert_count = 3'd3; coordinates = tri_crd; pix_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || line_buffer === '0) begin
            errors++;
            $display("FAIL midop_active busy=%b bits=%0d want busy=1 bits>0", busy,
                     $countones(line_buffer));
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({pix_valid, busy, bla_done, err} !== 4'b0 || {pix_x, pix_y} !== 16'h0 ||
            line_buffer !== '0) begin
            errors++;
            $display("FAIL midop_reset ctrl=%b pix=%h bits=%0d want 0", {pix_valid, busy,
                     bla_done, err}, {pix_x, pix_y}, $countones(line_buffer));
        end
        @(negedge clk);
        n_rst = 1'b1;
        model(2, diag);
        run_prim(2, diag, 0, -1, 200);
        checks++;
        if (seq_diff() !== 0 || done_cycle !== 27 || line_buffer !== exp_buf) begin
            errors++;
            $display("FAIL midop_rerun diffs=%0d cyc=%0d want 0/27", seq_diff(), done_cycle);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] crd = pack4(0, 0, 23, 23, 0, 23, 0, 0);
        model(3, crd);
        run_prim(3, crd, 0, 10, 400);
        checks++;
        if (seq_diff() !== 0 || done_cycle !== exp_done || done_count !== 1) begin
            errors++;
            $display("FAIL b2b_ignore diffs=%0d cyc=%0d cnt=%0d want 0/%0d/1", seq_diff(),
                     done_cycle, done_count, exp_done);
        end
        crd = pack4(5, 9, 2, 40, 0, 0, 0, 0);
        model(2, crd);
        run_prim(2, crd, 0, -1, 200);
        checks++;
        if (seq_diff() !== 0 || done_cycle !== exp_done) begin
            errors++;
            $display("FAIL b2b_next diffs=%0d cyc=%0d want 0/%0d", seq_diff(), done_cycle,
                     exp_done);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int n, mode;
            logic [63:0] crd;
            n    = $urandom_range(2, 4);
            mode = (it % 2 == 0) ? 0 : 2;
            crd  = pack4($urandom_range(0, 79), $urandom_range(0, 79), $urandom_range(0, 79),
                         $urandom_range(0, 79), $urandom_range(0, 79), $urandom_range(0, 79),
                         $urandom_range(0, 79), $urandom_range(0, 79));
            model(n, crd);
            run_prim(n, crd, mode, -1, 3000);
            checks++;
            if (seq_diff() !== 0 || line_buffer !== exp_buf) begin
                errors++;
                $display("FAIL rand_seq it=%0d n=%0d diffs=%0d bits=%0d want 0/%0d", it, n,
                         seq_diff(), $countones(line_buffer), $countones(exp_buf));
            end
            checks++;
            if (done_count !== 1 || stab_viol !== 0 || (mode == 0 && done_cycle !== exp_done))
            begin
                errors++;
                $display("FAIL rand_done it=%0d cnt=%0d stab=%0d cyc=%0d want 1/0/%0d", it,
                         done_count, stab_viol, done_cycle, exp_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_diag();
        test_triangle();
        test_backpressure();
        test_clip();
        test_illegal();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
